speed_control_sat: RTL

- Parametrised successor to the flash-read speed controller.
- Holds a divider terminal count (out_count_to) that the audio/flash read clock divider counts to.
- Each debounced press of speed_up / speed_down moves the count by STEP, saturating at MIN_COUNT/MAX_COUNT; speed_reset restores DEFAULT_COUNT.
- Sits between the keypad/button logic and the read-rate clock divider.

---
 rtl/speed_control_sat_pkg.sv | 21 ++
 rtl/speed_control_sat_btn_sync_edge.sv | 36 +++
 rtl/speed_control_sat.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/speed_control_sat_pkg.sv
// speed_ctrl_pkg: shared types and constants for the read-rate speed controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package speed_ctrl_pkg;

  // Flops in each button synchroniser before the edge-detect flop.
  localparam int SYNC_STAGES = 2;

  // Cycles after reset release during which button pulses are ignored. This
  // covers the time the synchronisers take to refill with a held level.
  localparam int GUARD_CYCLES = 3;

  // Command that wins arbitration in a given cycle.
  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_UP,
    CMD_DOWN,
    CMD_RESET
  } cmd_t;

endpackage

// File: rtl/speed_control_sat_btn_sync_edge.sv
// btn_sync_edge: synchronises one asynchronous button level and emits a rising-edge pulse.
// Latency: a level seen at edge E1 gives a pulse during the cycle after edge E(SYNC_STAGES).
// Backpressure: none; the pulse is one cycle wide and is not held.
//
// Ports:
//   clk, reset_n : clock and synchronous active-low reset
//   btn          : raw asynchronous button level
//   level        : synchronised level (last synchroniser stage)
//   pulse        : one-cycle pulse on a synchronised 0->1 transition
module btn_sync_edge #(
  parameter int SYNC_STAGES = 2  // must be >= 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic level,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign pulse = sync_q[SYNC_STAGES-1] & ~edge_q;

endmodule

// File: rtl/speed_control_sat.sv
// speed_control_sat: saturating divider terminal count driven by speed up/down/reset buttons.
// Latency: button high before edge E1 -> out_count_to (and flags) updated at edge E3.
// Backpressure: none; presses are level-edge events, simultaneous up+down is dropped.
//
// Ports:
//   clk, reset_n  : clock and synchronous active-low reset
//   speed_up      : async level; press lowers the count by STEP (faster), floor MIN_COUNT
//   speed_down    : async level; press raises the count by STEP (slower), ceiling MAX_COUNT
//   speed_reset   : async level; press restores DEFAULT_COUNT (wins over up/down)
//   out_count_to  : registered terminal count for the read-rate divider
//   at_min/at_max : registered, high while out_count_to sits on a bound
//   count_changed : one-cycle pulse coinciding with a new out_count_to value
//
// Optional build macro SPEED_CONTROL_HOLD_REPEAT_EN: a held up/down button
// re-steps every REPEAT_CYCLES cycles after the accepted press.
module speed_control_sat
  import speed_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned DEFAULT_COUNT = 1137,
  parameter int unsigned STEP          = 16,
  parameter int unsigned MIN_COUNT     = 1,
  parameter int unsigned MAX_COUNT     = 4095,
  parameter int unsigned REPEAT_CYCLES = 25000000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             speed_up,
  input  logic             speed_down,
  input  logic             speed_reset,
  output logic [WIDTH-1:0] out_count_to,
  output logic             at_min,
  output logic             at_max,
  output logic             count_changed
);

  localparam int W1 = WIDTH + 1;

  localparam logic [WIDTH-1:0] DEF_W  = WIDTH'(DEFAULT_COUNT);
  localparam logic [WIDTH-1:0] MIN_W  = WIDTH'(MIN_COUNT);
  localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
  localparam logic [WIDTH:0]   STEP_X = W1'(STEP);
  localparam logic [WIDTH:0]   MAX_X  = W1'(MAX_COUNT);
  // Below this the decrement would cross MIN_COUNT.
  localparam logic [WIDTH:0]   FLOOR_X = W1'(MIN_COUNT) + STEP_X;

  localparam logic [1:0] GUARD_DONE = 2'(GUARD_CYCLES);

  // ---------------------------------------------------------------------------
  // Button front ends
  // ---------------------------------------------------------------------------
  logic up_lvl, dn_lvl, rst_lvl;
  logic up_pls, dn_pls, rst_pls;

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_up (
    .clk    (clk),
    .reset_n(reset_n),
    .btn    (speed_up),
    .level  (up_lvl),
    .pulse  (up_pls)
  );

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dn (
    .clk    (clk),
    .reset_n(reset_n),
    .btn    (speed_down),
    .level  (dn_lvl),
    .pulse  (dn_pls)
  );

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rst (
    .clk    (clk),
    .reset_n(reset_n),
    .btn    (speed_reset),
    .level  (rst_lvl),
    .pulse  (rst_pls)
  );

  // A button held through reset refills the synchroniser and would look like
  // a fresh edge; pulses are ignored until the guard count has elapsed.
  logic [1:0] guard_q;
  logic       armed;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      guard_q <= 2'd0;
    end else if (guard_q != GUARD_DONE) begin
      guard_q <= guard_q + 2'd1;
    end
  end

  assign armed = (guard_q == GUARD_DONE);

  logic up_p, dn_p, rst_p;
  assign up_p  = up_pls  & armed;
  assign dn_p  = dn_pls  & armed;
  assign rst_p = rst_pls & armed;

  // ---------------------------------------------------------------------------
  // Hold repeat
  // ---------------------------------------------------------------------------
  logic rep_up, rep_dn;

`ifdef SPEED_CONTROL_HOLD_REPEAT_EN
  localparam logic [WIDTH-1:0] REP_LAST = WIDTH'(REPEAT_CYCLES - 1);

  logic             hold_act_q;
  logic             hold_up_q;
  logic [WIDTH-1:0] hold_cnt_q;
  logic             dir_lvl, both_lvl, rep_fire;

  always_comb begin
    dir_lvl  = hold_up_q ? up_lvl : dn_lvl;
    both_lvl = up_lvl & dn_lvl;
    rep_fire = hold_act_q & dir_lvl & ~both_lvl & ~rst_p & (hold_cnt_q == REP_LAST);
  end

  assign rep_up = rep_fire &  hold_up_q;
  assign rep_dn = rep_fire & ~hold_up_q;

  // The counter starts on an accepted single-direction press and stops on
  // release, a reset press or both buttons held.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hold_act_q <= 1'b0;
      hold_up_q  <= 1'b0;
      hold_cnt_q <= '0;
    end else if ((up_p ^ dn_p) && !rst_p) begin
      hold_act_q <= 1'b1;
      hold_up_q  <= up_p;
      hold_cnt_q <= '0;
    end else if (!hold_act_q) begin
      hold_cnt_q <= '0;
    end else if (rst_p || both_lvl || !dir_lvl) begin
      hold_act_q <= 1'b0;
      hold_cnt_q <= '0;
    end else if (rep_fire) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_q + WIDTH'(1);
    end
  end

  logic unused_lvl;
  assign unused_lvl = rst_lvl;
`else
  assign rep_up = 1'b0;
  assign rep_dn = 1'b0;

  logic unused_lvl;
  assign unused_lvl = ^{up_lvl, dn_lvl, rst_lvl};
  localparam int unsigned unused_repeat_cycles = REPEAT_CYCLES;
`endif

  // ---------------------------------------------------------------------------
  // Arbitration and saturating update
  // ---------------------------------------------------------------------------
  logic up_req, dn_req;
  cmd_t cmd;

  assign up_req = up_p | rep_up;
  assign dn_req = dn_p | rep_dn;

  always_comb begin
    cmd = CMD_NONE;
    if (rst_p) begin
      cmd = CMD_RESET;
    end else if (up_req && !dn_req) begin
      cmd = CMD_UP;
    end else if (dn_req && !up_req) begin
      cmd = CMD_DOWN;
    end
  end

  logic [WIDTH-1:0] count_q, next_count;
  logic [WIDTH:0]   cnt_x, inc_x;

  always_comb begin
    cnt_x      = {1'b0, count_q};
    inc_x      = cnt_x + STEP_X;
    next_count = count_q;
    unique case (cmd)
      CMD_RESET: next_count = DEF_W;
      CMD_UP:    next_count = (cnt_x < FLOOR_X) ? MIN_W : (count_q - STEP_W);
      CMD_DOWN:  next_count = (inc_x > MAX_X) ? MAX_W : inc_x[WIDTH-1:0];
      default:   next_count = count_q;
    endcase
  end

  logic at_min_q, at_max_q, changed_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q   <= DEF_W;
      at_min_q  <= (DEF_W == MIN_W);
      at_max_q  <= (DEF_W == MAX_W);
      changed_q <= 1'b0;
    end else begin
      count_q   <= next_count;
      at_min_q  <= (next_count == MIN_W);
      at_max_q  <= (next_count == MAX_W);
      changed_q <= (next_count != count_q);
    end
  end

  assign out_count_to  = count_q;
  assign at_min        = at_min_q;
  assign at_max        = at_max_q;
  assign count_changed = changed_q;

endmodule
